mor1kx_wb_arb2: RTL and testbench
=================================

Name: mor1kx_wb_arb2

Overview:
- Two-master to one-slave Wishbone B3 arbiter.
- Lets the mor1kx instruction bus (iwbm) and data bus (dwbm) share one external Wishbone slave port, for single-port memory systems.
- Sits between the core wrapper and the system interconnect.
- Holds the grant for the whole CYC of the granted master, so B3 bursts (CTI/BTE) are never split.

Parameters:
- ADDR_WIDTH, 32, address width for all ports.
- DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8.
- ARB_MODE, "ROUND_ROBIN", "ROUND_ROBIN" alternates on contention; "DATA_FIRST" gives dwbm fixed priority.
- TIMEOUT_WIDTH, 8, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m0_adr_i/m0_dat_i/m0_sel_i/m0_we_i/m0_cyc_i/m0_stb_i/m0_cti_i/m0_bte_i  in  ADDR_WIDTH/DATA_WIDTH/SEL/1/1/1/3/2  master 0 request (instruction bus)
- m0_dat_o/m0_ack_o/m0_err_o/m0_rty_o  out  DATA_WIDTH/1/1/1  master 0 response
- m1_* (same set as m0)  in/out  same widths  master 1 (data bus)
- s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o/s_cti_o/s_bte_o  out  same widths  slave request
- s_dat_i/s_ack_i/s_err_i/s_rty_i  in  DATA_WIDTH/1/1/1  slave response
- gnt_o  out  2  one-hot current grant {m1,m0}; 2'b00 when idle

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt_o=0, last_gnt=m1 (so m0 wins the first contended round-robin), all s_* outputs 0, all m*_ack/err/rty 0, m*_dat_o 0.
- State register, 2 bits: IDLE, GNT0, GNT1, ABORT (ABORT exists only with the optional feature).
- IDLE, transitions evaluated on the registered clock edge:
  - only m0_cyc_i=1 -> GNT0; only m1_cyc_i=1 -> GNT1.
  - both high, DATA_FIRST -> GNT1.
  - both high, ROUND_ROBIN -> grant the master that is not last_gnt.
  - neither high -> stay in IDLE.
- GNTx -> IDLE when mx_cyc_i=0. The grant is never revoked while mx_cyc_i=1.
- Arbitration latency: 1 cycle from request CYC to s_cyc_o. One idle cycle always follows every release, even with the other master pending.
- Slave request mux (combinational from the registered state):
  - GNTx: all s_* = mx_* inputs.
  - IDLE/ABORT: all s_* = 0.
- Response routing:
  - granted master receives s_ack_i/s_err_i/s_rty_i and s_dat_i.
  - non-granted master receives ack/err/rty = 0 and dat = 0. It never sees a response.
- Bursts: CTI/BTE pass through unchanged. A CTI=3'b111 end-of-burst only matters via the master dropping CYC.
- last_gnt updates on each IDLE->GNTx transition.
- Simultaneous release and new request from the same master: CYC low for at least one cycle returns to IDLE; normal arbitration follows.
- Reset mid-transfer: immediate return to reset values. No response is generated for the in-flight cycle.
- s_ack_i while IDLE (spurious) is ignored and not forwarded.

Optional Feature:
- Macro: MOR1KX_WB_ARB_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_WIDTH-bit counter clears on the grant transition and on any s_ack_i/s_err_i/s_rty_i.
  - It increments each cycle of GNTx with mx_stb_i=1 and no response.
  - On reaching all-ones: one-cycle mx_err_o=1, s_cyc_o/s_stb_o forced 0 that cycle, state -> ABORT.
  - ABORT -> IDLE when mx_cyc_i=0. Slave outputs stay 0 throughout ABORT.
- When undefined: no counter, no ABORT state; a stalled slave hangs the granted master indefinitely.

Decomposition:
- Package mor1kx_wb_arb_pkg:
  - state enum (IDLE, GNT0, GNT1, ABORT).
  - Wishbone CTI constants: CLASSIC 3'b000, INCR 3'b010, EOB 3'b111.
  - ARB_MODE string constants.
- One sub-module, mor1kx_wb_arb_wdog: the timeout counter, with inputs clear, count_en and output expire. It is instantiated only under the macro.

Test Plan:
- Single master: m0 CYC/STB at adr 0x100, slave acks after 2 cycles -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o pulses, m1_ack_o stays 0, gnt_o=2'b01.
- Contention, ROUND_ROBIN: both CYC high at reset exit -> m0 granted first. After m0 drops CYC: 1 IDLE cycle, then gnt_o=2'b10. Repeat -> m0 granted again.
- DATA_FIRST: both request repeatedly -> m1 granted every contended round, m0 only when m1_cyc_i=0.
- Burst integrity: m0 4-beat INCR burst (CTI 010,010,010,111), m1 requesting throughout -> all 4 acks reach m0, s_cti_o mirrors m0_cti_i, no grant change until m0 drops CYC.
- Async reset mid-burst: assert rst on beat 2 -> s_cyc_o=0 and gnt_o=0 in the same cycle, no ack forwarded.
- With MOR1KX_WB_ARB_TIMEOUT_EN and TIMEOUT_WIDTH=4, slave never acks -> m1_err_o pulses after 15 stalled cycles, s_cyc_o=0 from that cycle, return to IDLE after m1 drops CYC.

Source files
------------

// File: rtl/mor1kx_wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// mor1kx_wb_arb_pkg
// Shared definitions for the two-master Wishbone B3 arbiter:
//   - state_t      : arbiter state encoding (ABORT is reachable only when the
//                    MOR1KX_WB_ARB_TIMEOUT_EN watchdog is compiled in)
//   - CTI_*        : Wishbone B3 cycle type identifiers seen on the bus
//   - ARB_*        : legal values of the ARB_MODE parameter
//   - gnt_onehot() : one-hot {m1,m0} grant vector for a winner
// ---------------------------------------------------------------------------
package mor1kx_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT0  = 2'b01,
    GNT1  = 2'b10,
    ABORT = 2'b11
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam string ARB_ROUND_ROBIN = "ROUND_ROBIN";
  localparam string ARB_DATA_FIRST  = "DATA_FIRST";

  function automatic logic [1:0] gnt_onehot(input logic pick_m1);
    return pick_m1 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mor1kx_wb_arb_wdog.sv
// ---------------------------------------------------------------------------
// mor1kx_wb_arb_wdog
// Bus watchdog counter for the arbiter. Counts stalled cycles of the granted
// master and flags expiry when the counter reaches all-ones.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the counter (has priority over count_en)
//   count_en  : advance the counter by one this cycle
//   expire    : counter is all-ones
// ---------------------------------------------------------------------------
module mor1kx_wb_arb_wdog #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  logic [WIDTH-1:0] count;

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expire = &count;

endmodule

// File: rtl/mor1kx_wb_arb2.sv
// ---------------------------------------------------------------------------
// mor1kx_wb_arb2
// Two-master to one-slave Wishbone B3 arbiter. Master 0 is the mor1kx
// instruction bus, master 1 the data bus. A grant is held for the whole CYC
// of the winner so B3 bursts are never split; one idle cycle follows every
// release. ARB_MODE "ROUND_ROBIN" alternates on contention, "DATA_FIRST"
// always favours master 1.
// Optional: define MOR1KX_WB_ARB_TIMEOUT_EN to add a watchdog that errors out
// a master whose slave stalls for 2**TIMEOUT_WIDTH-1 strobed cycles.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   m0_*_i / m0_*_o     : master 0 request in / response out
//   m1_*_i / m1_*_o     : master 1 request in / response out
//   s_*_o / s_*_i       : shared slave request out / response in
//   gnt_o               : one-hot current grant {m1,m0}, 2'b00 when not granted
// ---------------------------------------------------------------------------
module mor1kx_wb_arb2
  import mor1kx_wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter string       ARB_MODE      = "ROUND_ROBIN",
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // master 0 (instruction bus)
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic [2:0]              m0_cti_i,
  input  logic [1:0]              m0_bte_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  // master 1 (data bus)
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic [2:0]              m1_cti_i,
  input  logic [1:0]              m1_bte_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  // slave
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  // grant status
  output logic [1:0]              gnt_o
);

  localparam bit DATA_FIRST = (ARB_MODE == ARB_DATA_FIRST);

  if (TIMEOUT_WIDTH < 2) begin : g_bad_timeout_width
    $error("mor1kx_wb_arb2: TIMEOUT_WIDTH must be at least 2");
  end
  if (ARB_MODE != ARB_ROUND_ROBIN && ARB_MODE != ARB_DATA_FIRST) begin : g_bad_arb_mode
    $error("mor1kx_wb_arb2: ARB_MODE must be ROUND_ROBIN or DATA_FIRST");
  end

  state_t state;
  logic   last_gnt;     // 1: m1 won the last arbitration, 0: m0
  logic   pick_m1;      // winner if arbitration happened this cycle
  logic   owner_cyc;    // CYC of the master holding (or aborted on) the bus
  logic   granted;
  logic   resp_any;
  logic   timeout_hit;

  // last_gnt always names the current owner while in GNTx/ABORT.
  assign owner_cyc = last_gnt ? m1_cyc_i : m0_cyc_i;
  assign granted   = (state == GNT0) || (state == GNT1);
  assign resp_any  = s_ack_i | s_err_i | s_rty_i;

  always_comb begin
    pick_m1 = m1_cyc_i;
    if (m0_cyc_i && m1_cyc_i) begin
      pick_m1 = DATA_FIRST ? 1'b1 : ~last_gnt;
    end
  end

`ifdef MOR1KX_WB_ARB_TIMEOUT_EN
  logic owner_stb;
  logic wd_expire;

  assign owner_stb = last_gnt ? m1_stb_i : m0_stb_i;

  // Clearing throughout IDLE makes every fresh grant start from zero.
  mor1kx_wb_arb_wdog #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state == IDLE) || resp_any),
    .count_en (granted && owner_stb && !resp_any),
    .expire   (wd_expire)
  );

  // A response arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = granted && wd_expire && !resp_any;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_o    <= 2'b00;
      last_gnt <= 1'b1;   // m0 wins the first contended round-robin round
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            state    <= pick_m1 ? GNT1 : GNT0;
            gnt_o    <= gnt_onehot(pick_m1);
            last_gnt <= pick_m1;
          end
        end
        GNT0, GNT1: begin
          if (!owner_cyc) begin
            state <= IDLE;
            gnt_o <= 2'b00;
          end else if (timeout_hit) begin
            state <= ABORT;
            gnt_o <= 2'b00;
          end
        end
        ABORT: begin
          if (!owner_cyc) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block can leave a value held, which would infer a latch.
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    unique case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i & ~timeout_hit;
        s_stb_o  = m0_stb_i & ~timeout_hit;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | timeout_hit;
        m0_rty_o = s_rty_i;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i & ~timeout_hit;
        s_stb_o  = m1_stb_i & ~timeout_hit;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | timeout_hit;
        m1_rty_o = s_rty_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mor1kx_wb_arb2.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_wb_arb2
// Drives a ROUND_ROBIN and a DATA_FIRST instance with the same random master
// and slave traffic. A cycle-level reference model of the arbitration rules
// produces the expected outputs, which are queued; a monitor on the falling
// edge pops them and compares against both instances.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mor1kx_wb_arb2;
  import mor1kx_wb_arb_pkg::*;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int SW       = DW / 8;
  localparam int TW       = 4;
  localparam int TO_LIMIT = (1 << TW) - 1;
  localparam int N_CYCLES = 1600;
  localparam int NONE     = -1;
  localparam int ABORTED  = 2;
`ifdef MOR1KX_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]    gnt;
    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [SW-1:0] s_sel;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic [1:0]    ack;   // {m1,m0}
    logic [1:0]    err;
    logic [1:0]    rty;
    logic [DW-1:0] m0_dat;
    logic [DW-1:0] m1_dat;
  } obs_t;

  typedef struct {
    int   inst;
    int   cycle;
    obs_t o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master requests, indexed by master
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic          m_we  [2];
  logic          m_cyc [2];
  logic          m_stb [2];
  logic [2:0]    m_cti [2];
  logic [1:0]    m_bte [2];
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_rty;

  // DUT outputs, indexed by instance (0: ROUND_ROBIN, 1: DATA_FIRST)
  wire [AW-1:0] o_s_adr [2];
  wire [DW-1:0] o_s_dat [2];
  wire [SW-1:0] o_s_sel [2];
  wire          o_s_we  [2];
  wire          o_s_cyc [2];
  wire          o_s_stb [2];
  wire [2:0]    o_s_cti [2];
  wire [1:0]    o_s_bte [2];
  wire [DW-1:0] o_m0_dat [2];
  wire          o_m0_ack [2];
  wire          o_m0_err [2];
  wire          o_m0_rty [2];
  wire [DW-1:0] o_m1_dat [2];
  wire          o_m1_ack [2];
  wire          o_m1_err [2];
  wire          o_m1_rty [2];
  wire [1:0]    o_gnt    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mor1kx_wb_arb2 #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .ARB_MODE      (g == 0 ? ARB_ROUND_ROBIN : ARB_DATA_FIRST),
      .TIMEOUT_WIDTH (TW)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .m0_adr_i (m_adr[0]), .m0_dat_i (m_dat[0]), .m0_sel_i (m_sel[0]),
      .m0_we_i  (m_we[0]),  .m0_cyc_i (m_cyc[0]), .m0_stb_i (m_stb[0]),
      .m0_cti_i (m_cti[0]), .m0_bte_i (m_bte[0]),
      .m0_dat_o (o_m0_dat[g]), .m0_ack_o (o_m0_ack[g]),
      .m0_err_o (o_m0_err[g]), .m0_rty_o (o_m0_rty[g]),
      .m1_adr_i (m_adr[1]), .m1_dat_i (m_dat[1]), .m1_sel_i (m_sel[1]),
      .m1_we_i  (m_we[1]),  .m1_cyc_i (m_cyc[1]), .m1_stb_i (m_stb[1]),
      .m1_cti_i (m_cti[1]), .m1_bte_i (m_bte[1]),
      .m1_dat_o (o_m1_dat[g]), .m1_ack_o (o_m1_ack[g]),
      .m1_err_o (o_m1_err[g]), .m1_rty_o (o_m1_rty[g]),
      .s_adr_o  (o_s_adr[g]), .s_dat_o (o_s_dat[g]), .s_sel_o (o_s_sel[g]),
      .s_we_o   (o_s_we[g]),  .s_cyc_o (o_s_cyc[g]), .s_stb_o (o_s_stb[g]),
      .s_cti_o  (o_s_cti[g]), .s_bte_o (o_s_bte[g]),
      .s_dat_i  (s_dat), .s_ack_i (s_ack), .s_err_i (s_err), .s_rty_i (s_rty),
      .gnt_o    (o_gnt[g])
    );
  end

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input int inst, input int cycle,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cycle=%0d: got %0h, expected %0h",
               name, inst, cycle, act, exp);
    end
  endtask

  function automatic obs_t sample(input int i);
    obs_t a;
    a.gnt    = o_gnt[i];
    a.s_cyc  = o_s_cyc[i];
    a.s_stb  = o_s_stb[i];
    a.s_we   = o_s_we[i];
    a.s_adr  = o_s_adr[i];
    a.s_dat  = o_s_dat[i];
    a.s_sel  = o_s_sel[i];
    a.s_cti  = o_s_cti[i];
    a.s_bte  = o_s_bte[i];
    a.ack    = {o_m1_ack[i], o_m0_ack[i]};
    a.err    = {o_m1_err[i], o_m0_err[i]};
    a.rty    = {o_m1_rty[i], o_m0_rty[i]};
    a.m0_dat = o_m0_dat[i];
    a.m1_dat = o_m1_dat[i];
    return a;
  endfunction

  // ---------------- reference model ----------------
  // owner: NONE, master index 0/1, or ABORTED (bus held by a timed-out master)
  int owner   [2];
  int last_w  [2];
  int abort_m [2];
  int wd_cnt  [2];
  bit hit     [2];
  bit p_hit   [2];
  bit p_cyc   [2];
  bit p_stb   [2];
  bit p_resp;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i]   = NONE;
      last_w[i]  = 1;
      abort_m[i] = 0;
      wd_cnt[i]  = 0;
      p_hit[i]   = 1'b0;
    end
  endfunction

  // Advance instance i over the clock edge that just happened, using the
  // inputs that were present during the previous cycle.
  function automatic void model_step(input int i);
    int w;
    if (owner[i] == 0 || owner[i] == 1) begin
      if (p_resp) wd_cnt[i] = 0;
      else if (p_stb[owner[i]]) wd_cnt[i] = (wd_cnt[i] + 1) & TO_LIMIT;
    end else if (owner[i] == NONE) begin
      wd_cnt[i] = 0;
    end
    if (owner[i] == NONE) begin
      w = NONE;
      if (p_cyc[0] && p_cyc[1]) w = (i == 1) ? 1 : 1 - last_w[i];
      else if (p_cyc[0]) w = 0;
      else if (p_cyc[1]) w = 1;
      if (w != NONE) begin
        owner[i]  = w;
        last_w[i] = w;
        wd_cnt[i] = 0;
      end
    end else if (owner[i] == ABORTED) begin
      if (!p_cyc[abort_m[i]]) owner[i] = NONE;
    end else if (!p_cyc[owner[i]]) begin
      owner[i] = NONE;
    end else if (p_hit[i]) begin
      abort_m[i] = owner[i];
      owner[i]   = ABORTED;
    end
  endfunction

  function automatic obs_t expect_obs(input int i);
    obs_t e = '0;
    int   m;
    bit   resp = s_ack | s_err | s_rty;
    hit[i] = 1'b0;
    if (owner[i] == 0 || owner[i] == 1) begin
      m      = owner[i];
      hit[i] = TO_EN && (wd_cnt[i] == TO_LIMIT) && !resp;
      e.gnt    = (m == 0) ? 2'b01 : 2'b10;
      e.s_adr  = m_adr[m];
      e.s_dat  = m_dat[m];
      e.s_sel  = m_sel[m];
      e.s_we   = m_we[m];
      e.s_cyc  = m_cyc[m] & ~hit[i];
      e.s_stb  = m_stb[m] & ~hit[i];
      e.s_cti  = m_cti[m];
      e.s_bte  = m_bte[m];
      e.ack[m] = s_ack;
      e.err[m] = s_err | hit[i];
      e.rty[m] = s_rty;
      if (m == 0) e.m0_dat = s_dat;
      else        e.m1_dat = s_dat;
    end
    return e;
  endfunction

  // ---------------- master / slave stimulus ----------------
  int beats_left [2];
  bit got_resp   [2];
  bit got_end    [2];

  task automatic start_txn(input int m);
    beats_left[m] = $urandom_range(1, 4);
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_adr[m] = $urandom & ~32'h3;
    m_dat[m] = $urandom;
    m_sel[m] = SW'($urandom);
    m_we[m]  = 1'($urandom);
    m_bte[m] = 2'($urandom);
    m_cti[m] = (beats_left[m] == 1) ? CTI_CLASSIC : CTI_INCR;
  endtask

  task automatic drive_masters(input bit force_start);
    for (int m = 0; m < 2; m++) begin
      if (m_cyc[m]) begin
        if (got_resp[m]) begin
          beats_left[m]--;
          if (beats_left[m] == 0 || got_end[m]) begin
            m_cyc[m] = 1'b0;
            m_stb[m] = 1'b0;
          end else begin
            m_adr[m] = m_adr[m] + 32'd4;
            m_dat[m] = $urandom;
            m_cti[m] = (beats_left[m] == 1) ? CTI_EOB : CTI_INCR;
          end
        end
      end else if (force_start || $urandom_range(0, 1) == 1) begin
        start_txn(m);
      end
    end
  endtask

  task automatic drive_slave(input bit quiet, input bit force_ack);
    s_dat = $urandom;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    if (!quiet) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: s_ack = 1'b1;
        4:          s_err = 1'b1;
        5:          s_rty = 1'b1;
        default:    ;
      endcase
    end
    if (force_ack) s_ack = 1'b1;
  endtask

  // ---------------- stimulus + expectation producer ----------------
  initial begin
    obs_t e;
    bit   pulse;
    for (int m = 0; m < 2; m++) begin
      m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0;
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_cti[m] = '0; m_bte[m] = '0;
      beats_left[m] = 0; got_resp[m] = 1'b0; got_end[m] = 1'b0;
    end
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    model_reset();

    for (int cyc_n = 0; cyc_n < N_CYCLES; cyc_n++) begin
      @(posedge clk);
      #1;
      if (cyc_n < 3) begin
        rst = 1'b1;
        model_reset();
      end else if (rst) begin
        rst = 1'b0;               // the edge just taken was still in reset
      end else begin
        model_step(0);
        model_step(1);
      end

      // both masters request across reset exit; periodic resets mid-traffic
      pulse = (cyc_n % 350 == 200);
      drive_masters(cyc_n == 2);
      drive_slave(cyc_n >= 700 && cyc_n < 760, pulse);
      if (pulse) begin
        #2;
        rst = 1'b1;
        model_reset();
      end

      for (int i = 0; i < 2; i++) begin
        e = expect_obs(i);
        exp_q.push_back('{inst: i, cycle: cyc_n, o: e});
        if (i == 0) begin
          for (int m = 0; m < 2; m++) begin
            got_resp[m] = m_stb[m] && (e.ack[m] || e.err[m] || e.rty[m]);
            got_end[m]  = e.err[m] || e.rty[m];
          end
        end
      end
      for (int m = 0; m < 2; m++) begin
        p_cyc[m] = m_cyc[m];
        p_stb[m] = m_stb[m];
      end
      p_resp = s_ack | s_err | s_rty;
      p_hit  = hit;
    end

    @(negedge clk);
    #1;
    check("queue_drained", -1, N_CYCLES, 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    obs_t a;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a = sample(x.inst);
        check("gnt",    x.inst, x.cycle, 64'(a.gnt),    64'(x.o.gnt));
        check("s_cyc",  x.inst, x.cycle, 64'(a.s_cyc),  64'(x.o.s_cyc));
        check("s_stb",  x.inst, x.cycle, 64'(a.s_stb),  64'(x.o.s_stb));
        check("s_we",   x.inst, x.cycle, 64'(a.s_we),   64'(x.o.s_we));
        check("s_adr",  x.inst, x.cycle, 64'(a.s_adr),  64'(x.o.s_adr));
        check("s_dat",  x.inst, x.cycle, 64'(a.s_dat),  64'(x.o.s_dat));
        check("s_sel",  x.inst, x.cycle, 64'(a.s_sel),  64'(x.o.s_sel));
        check("s_cti",  x.inst, x.cycle, 64'(a.s_cti),  64'(x.o.s_cti));
        check("s_bte",  x.inst, x.cycle, 64'(a.s_bte),  64'(x.o.s_bte));
        check("ack",    x.inst, x.cycle, 64'(a.ack),    64'(x.o.ack));
        check("err",    x.inst, x.cycle, 64'(a.err),    64'(x.o.err));
        check("rty",    x.inst, x.cycle, 64'(a.rty),    64'(x.o.rty));
        check("m0_dat", x.inst, x.cycle, 64'(a.m0_dat), 64'(x.o.m0_dat));
        check("m1_dat", x.inst, x.cycle, 64'(a.m1_dat), 64'(x.o.m1_dat));
      end
    end
  end

endmodule
